dense_layer_param: RTL and testbench

//  Parametrised successor of the fixed dense1/dense2 stages in the forward pass pipeline.

---
 rtl/dense_layer_param_pkg.sv | 39 +++
 rtl/dense_layer_param_if.sv | 29 ++
 rtl/dense_layer_param_mac_lane.sv | 44 ++++
 rtl/dense_layer_param.sv | 188 ++++++++++++++++++
 tb/tb_dense_layer_param.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/dense_layer_param_pkg.sv
// Shared types and helpers for the dense stage: FSM encoding, activation modes,
// and the rescale/activate/saturate helper used by the neighbouring pipeline stages.
package dense_layer_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int ACT_LINEAR = 0;
    localparam int ACT_RELU   = 1;

    // Drops FRAC bits (floor), optionally clamps negatives, then saturates to data_w signed.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] v,
                                                     input int frac,
                                                     input int data_w,
                                                     input logic relu);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = v >>> frac;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (relu && (s < 0)) begin
            s = '0;
        end
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/dense_layer_param_if.sv
// Streaming activation input and single-beat neuron-vector output of the dense stage.
interface dense_layer_param_if
    import dense_layer_param_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int OUT_LEN = 10
);
    logic                        ena;
    logic                        frame_start_in;
    logic                        frame_end_in;
    logic signed [DATA_W-1:0]    dense_input;
    logic                        busy;
    logic                        valid;
    logic                        frame_start_out;
    logic                        frame_end_out;
    logic [OUT_LEN*DATA_W-1:0]   dense_out;
    logic                        err_overflow;
    logic                        err_short;

    modport master (
        output ena, frame_start_in, frame_end_in, dense_input,
        input  busy, valid, frame_start_out, frame_end_out, dense_out, err_overflow, err_short
    );

    modport slave (
        input  ena, frame_start_in, frame_end_in, dense_input,
        output busy, valid, frame_start_out, frame_end_out, dense_out, err_overflow, err_short
    );
endinterface

// File: rtl/dense_layer_param_mac_lane.sv
// One MAC lane: registered product, clearable accumulator, and the bias/activation/saturation
// result that is sampled when the group is written out.
module dense_layer_param_mac_lane
    import dense_layer_param_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 40,
    parameter int ACT_MODE = ACT_LINEAR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_v,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] bias,
    output logic        [DATA_W-1:0] result
);
    logic signed [2*DATA_W-1:0] p_q;
    logic                       p_v;
    logic signed [ACC_W-1:0]    acc;
    logic signed [63:0]         sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            p_v <= 1'b0;
            acc <= '0;
        end else begin
            p_v <= in_v;
            if (in_v) begin
                p_q <= (2*DATA_W)'(x) * (2*DATA_W)'(w);
            end
            if (p_v) begin
                acc <= acc + ACC_W'(p_q);
            end
        end
    end

    // Bias is aligned to the product's 2*FRAC scaling before the final shift.
    assign sum    = 64'(acc) + (64'(bias) <<< FRAC);
    assign result = DATA_W'(sat_round(sum, FRAC, DATA_W, ACT_MODE == ACT_RELU));

endmodule

// File: rtl/dense_layer_param.sv
// Parametrised dense layer: buffers one frame of activations, then runs LANES MACs per neuron
// group against constant weight/bias images and presents the whole neuron vector on one beat.
module dense_layer_param
    import dense_layer_param_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 40,
    parameter int IN_LEN   = 980,
    parameter int OUT_LEN  = 10,
    parameter int LANES    = 2,
    parameter int ACT_MODE = ACT_LINEAR,
    // Word g*IN_LEN+i holds {lane LANES-1 .. lane 0} weights; bias n sits at [n*DATA_W +: DATA_W].
    parameter logic [OUT_LEN*IN_LEN*DATA_W-1:0] W_INIT = '0,
    parameter logic [OUT_LEN*DATA_W-1:0]        B_INIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    dense_layer_param_if.slave bus
);
    localparam int G      = OUT_LEN / LANES;
    localparam int WORD_W = LANES * DATA_W;
    localparam int AW     = $clog2(IN_LEN);
    localparam int RW     = $clog2(G * IN_LEN);
    localparam int SW     = $clog2(OUT_LEN);
    localparam logic [AW-1:0] LAST      = AW'(IN_LEN - 1);
    localparam logic [SW-1:0] LAST_BASE = SW'(OUT_LEN - LANES);
    localparam logic [G*IN_LEN-1:0][WORD_W-1:0] W_ROM = W_INIT;
    localparam logic [OUT_LEN-1:0][DATA_W-1:0]  B_ROM = B_INIT;

    state_t state, state_next;
    logic [AW-1:0] wr_ptr, wr_addr, rd_idx;
    logic [RW-1:0] rom_addr;
    logic [SW-1:0] slot_base;
    logic          drain_q;
    logic          store, restart, issue, do_write, short_hit, overflow_hit, busy_c;
    logic          rd_v;
    logic          err_overflow_q, err_short_q;
    logic [IN_LEN-1:0] vld;
    logic signed [DATA_W-1:0] buf_mem [IN_LEN];
    logic signed [DATA_W-1:0] x_q;
    logic [WORD_W-1:0] w_q;
    logic [DATA_W-1:0] lane_res [LANES];
    logic [OUT_LEN-1:0][DATA_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame_start inside CAPTURE rewinds to address 0; reaching the last address also ends capture.
    always_comb begin
        state_next = state;
        store      = 1'b0;
        restart    = 1'b0;
        issue      = 1'b0;
        do_write   = 1'b0;
        wr_addr    = wr_ptr;
        case (state)
            ST_IDLE: begin
                if (bus.ena && bus.frame_start_in) begin
                    store      = 1'b1;
                    restart    = 1'b1;
                    wr_addr    = '0;
                    state_next = bus.frame_end_in ? ST_MAC : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.ena) begin
                    store   = 1'b1;
                    restart = bus.frame_start_in;
                    if (restart) begin
                        wr_addr = '0;
                    end
                    if (bus.frame_end_in || (wr_addr == LAST)) begin
                        state_next = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                issue = 1'b1;
                if (rd_idx == LAST) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                do_write   = 1'b1;
                state_next = (slot_base == LAST_BASE) ? ST_DONE : ST_MAC;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy_c       = (state != ST_IDLE) && (state != ST_CAPTURE);
    assign short_hit    = store && bus.frame_end_in && (wr_addr != LAST);
    assign overflow_hit = bus.ena && busy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_idx         <= '0;
            rom_addr       <= '0;
            slot_base      <= '0;
            drain_q        <= 1'b0;
            rd_v           <= 1'b0;
            vld            <= '0;
            out_q          <= '0;
            err_overflow_q <= 1'b0;
            err_short_q    <= 1'b0;
        end else begin
            if (store) begin
                if (restart) begin
                    vld <= '0;
                end
                vld[wr_addr] <= 1'b1;
                wr_ptr       <= wr_addr + AW'(1);
            end
            rd_v    <= issue;
            drain_q <= (state == ST_DRAIN) ? ~drain_q : 1'b0;
            if ((state == ST_IDLE) || (state == ST_CAPTURE)) begin
                rd_idx    <= '0;
                rom_addr  <= '0;
                slot_base <= '0;
            end
            if (issue) begin
                rd_idx   <= (rd_idx == LAST) ? '0 : rd_idx + AW'(1);
                rom_addr <= rom_addr + RW'(1);
            end
            if (do_write) begin
                for (int l = 0; l < LANES; l++) begin
                    out_q[slot_base + SW'(l)] <= lane_res[l];
                end
                slot_base <= slot_base + SW'(LANES);
            end
            if (overflow_hit) begin
                err_overflow_q <= 1'b1;
            end
            if (short_hit) begin
                err_short_q <= 1'b1;
            end
        end
    end

    // Entries never written in this frame read back as zero through their valid bit.
    always_ff @(posedge clk) begin
        if (store) begin
            buf_mem[wr_addr] <= bus.dense_input;
        end
        x_q <= vld[rd_idx] ? buf_mem[rd_idx] : '0;
        w_q <= W_ROM[rom_addr];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dense_layer_param_mac_lane #(
            .DATA_W  (DATA_W),
            .FRAC    (FRAC),
            .ACC_W   (ACC_W),
            .ACT_MODE(ACT_MODE)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   ((state == ST_IDLE) || (state == ST_WRITE)),
            .in_v  (rd_v),
            .x     (x_q),
            .w     (w_q[l*DATA_W +: DATA_W]),
            .bias  (B_ROM[slot_base + SW'(l)]),
            .result(lane_res[l])
        );
    end

    assign bus.busy            = busy_c;
    assign bus.valid           = (state == ST_DONE);
    assign bus.frame_start_out = (state == ST_DONE);
    assign bus.frame_end_out   = (state == ST_DONE);
    assign bus.dense_out       = out_q;
    assign bus.err_overflow    = err_overflow_q;
    assign bus.err_short       = err_short_q;

endmodule

// File: tb/tb_dense_layer_param.sv
// Three dense stages (linear identity, ReLU identity, saturating all-0x7FFF) share one input
// stream; a negedge monitor pops per-instance expected vectors and checks data, latency and flags.
module tb_dense_layer_param;
    import dense_layer_param_pkg::*;

    localparam logic [255:0] W_ID  = 256'h01000000_00000100_00000000_00000000_00000000_00000000_01000000_00000100;
    localparam logic [255:0] W_MAX = {16{16'h7FFF}};
    localparam int LATENCY = 2 * 7 + 1;

    typedef struct {
        logic [63:0] data;
        int          end_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        fs  = 1'b0;
    logic        fe  = 1'b0;
    logic [15:0] din = '0;
    int          cyc = 0;
    int          end_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb [3][$];

    dense_layer_param_if #(.DATA_W(16), .OUT_LEN(4)) bus_lin ();
    dense_layer_param_if #(.DATA_W(16), .OUT_LEN(4)) bus_relu ();
    dense_layer_param_if #(.DATA_W(16), .OUT_LEN(4)) bus_sat ();

    assign bus_lin.ena  = ena;  assign bus_lin.frame_start_in  = fs;
    assign bus_lin.frame_end_in  = fe;  assign bus_lin.dense_input  = din;
    assign bus_relu.ena = ena;  assign bus_relu.frame_start_in = fs;
    assign bus_relu.frame_end_in = fe;  assign bus_relu.dense_input = din;
    assign bus_sat.ena  = ena;  assign bus_sat.frame_start_in  = fs;
    assign bus_sat.frame_end_in  = fe;  assign bus_sat.dense_input  = din;

    dense_layer_param #(.DATA_W(16), .FRAC(8), .ACC_W(40), .IN_LEN(4), .OUT_LEN(4), .LANES(2),
                        .ACT_MODE(ACT_LINEAR), .W_INIT(W_ID), .B_INIT(64'h0))
        dut_lin (.clk(clk), .rst(rst), .bus(bus_lin));
    dense_layer_param #(.DATA_W(16), .FRAC(8), .ACC_W(40), .IN_LEN(4), .OUT_LEN(4), .LANES(2),
                        .ACT_MODE(ACT_RELU), .W_INIT(W_ID), .B_INIT(64'h0))
        dut_relu (.clk(clk), .rst(rst), .bus(bus_relu));
    dense_layer_param #(.DATA_W(16), .FRAC(8), .ACC_W(40), .IN_LEN(4), .OUT_LEN(4), .LANES(2),
                        .ACT_MODE(ACT_LINEAR), .W_INIT(W_MAX), .B_INIT(64'h0))
        dut_sat (.clk(clk), .rst(rst), .bus(bus_sat));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_output(input int k, input logic [63:0] got, input logic fso, input logic feo);
        exp_t e;
        if (sb[k].size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_valid dut%0d: valid=1 with nothing outstanding, required 0", k);
            return;
        end
        e = sb[k].pop_front();
        check_eq($sformatf("dense_out dut%0d", k), got, e.data);
        check_eq($sformatf("latency dut%0d", k), 64'(cyc - e.end_cyc), 64'(LATENCY));
        check_eq($sformatf("frame flags dut%0d", k), 64'({fso, feo}), 64'd3);
    endtask

    // Monitor: independent of the stimulus thread.
    always @(negedge clk) begin
        if (bus_lin.valid)  check_output(0, bus_lin.dense_out,  bus_lin.frame_start_out,  bus_lin.frame_end_out);
        if (bus_relu.valid) check_output(1, bus_relu.dense_out, bus_relu.frame_start_out, bus_relu.frame_end_out);
        if (bus_sat.valid)  check_output(2, bus_sat.dense_out,  bus_sat.frame_start_out,  bus_sat.frame_end_out);
    end

    task automatic apply_stimulus(input logic [63:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ena = 1'b1;
            din = frame[i*16 +: 16];
            fs  = (i == 0);
            fe  = (i == n - 1);
            if (i == n - 1) end_cyc = cyc;
        end
        @(posedge clk); #1;
        ena = 1'b0; fs = 1'b0; fe = 1'b0; din = '0;
    endtask

    task automatic push_expect(input logic [63:0] lin, input logic [63:0] relu, input logic [63:0] sat);
        sb[0].push_back('{data: lin,  end_cyc: end_cyc});
        sb[1].push_back('{data: relu, end_cyc: end_cyc});
        sb[2].push_back('{data: sat,  end_cyc: end_cyc});
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (((sb[0].size() + sb[1].size() + sb[2].size()) != 0) && (t < 100)) begin
            @(posedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            $display("[TB] FAIL %s drain: %0d results still outstanding, required 0", tag,
                     sb[0].size() + sb[1].size() + sb[2].size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " dense_out lin"},  bus_lin.dense_out,  64'h0);
        check_eq({tag, " dense_out relu"}, bus_relu.dense_out, 64'h0);
        check_eq({tag, " dense_out sat"},  bus_sat.dense_out,  64'h0);
        check_eq({tag, " status lin"},  64'({bus_lin.busy,  bus_lin.valid,  bus_lin.err_short,  bus_lin.err_overflow}),  64'h0);
        check_eq({tag, " status relu"}, 64'({bus_relu.busy, bus_relu.valid, bus_relu.err_short, bus_relu.err_overflow}), 64'h0);
        check_eq({tag, " status sat"},  64'({bus_sat.busy,  bus_sat.valid,  bus_sat.err_short,  bus_sat.err_overflow}),  64'h0);
    endtask

    task automatic check_err(input string tag, input logic sh, input logic ov);
        check_eq({tag, " errors lin"},  64'({bus_lin.err_short,  bus_lin.err_overflow}),  64'({sh, ov}));
        check_eq({tag, " errors relu"}, 64'({bus_relu.err_short, bus_relu.err_overflow}), 64'({sh, ov}));
        check_eq({tag, " errors sat"},  64'({bus_sat.err_short,  bus_sat.err_overflow}),  64'({sh, ov}));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("power-on");

        // Mixed-sign frame; ReLU zeroes neuron 2, the all-max weights saturate high.
        apply_stimulus(64'h0080_FF00_0200_0100, 4);
        push_expect(64'h0080_FF00_0200_0100, 64'h0080_0000_0200_0100, 64'h7FFF_7FFF_7FFF_7FFF);
        wait_drain("mixed");

        apply_stimulus(64'h7FFF_7FFF_7FFF_7FFF, 4);
        push_expect(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF);
        wait_drain("all max");

        apply_stimulus(64'h8000_8000_8000_8000, 4);
        push_expect(64'h8000_8000_8000_8000, 64'h0000_0000_0000_0000, 64'h8000_8000_8000_8000);
        wait_drain("all min");
        check_err("before short", 1'b0, 1'b0);

        // Two-sample frame: stale 0x8000 entries from the previous frame must read as 0.
        apply_stimulus(64'h0000_0000_0400_0300, 2);
        push_expect(64'h0000_0000_0400_0300, 64'h0000_0000_0400_0300, 64'h7FFF_7FFF_7FFF_7FFF);
        wait_drain("short");
        check_err("after short", 1'b1, 1'b0);

        // Samples while busy are dropped; 32767*160/256 floors to 0x4FFF.
        apply_stimulus(64'h0040_0030_0020_0010, 4);
        push_expect(64'h0040_0030_0020_0010, 64'h0040_0030_0020_0010, 64'h4FFF_4FFF_4FFF_4FFF);
        repeat (2) @(posedge clk);
        #1 ena = 1'b1; din = 16'h7FFF; fs = 1'b1;
        @(posedge clk); #1 ena = 1'b0; fs = 1'b0;
        @(posedge clk); #1 ena = 1'b1; din = 16'h1234; fe = 1'b1;
        @(posedge clk); #1 ena = 1'b0; fe = 1'b0; din = '0;
        wait_drain("overflow");
        check_err("after overflow", 1'b1, 1'b1);

        // Abort mid-MAC: nothing is expected, so any valid is flagged by the monitor.
        apply_stimulus(64'h1111_1111_1111_1111, 4);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("mid-MAC reset");
        repeat (30) @(posedge clk);

        apply_stimulus(64'h0400_0300_0200_0100, 4);
        push_expect(64'h0400_0300_0200_0100, 64'h0400_0300_0200_0100, 64'h7FFF_7FFF_7FFF_7FFF);
        wait_drain("after abort");
        check_err("after abort", 1'b0, 1'b0);

        check_eq("outstanding lin",  64'(sb[0].size()), 64'h0);
        check_eq("outstanding relu", 64'(sb[1].size()), 64'h0);
        check_eq("outstanding sat",  64'(sb[2].size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
